// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module   : dcache
// Purpose  : direct-mapped, write-through, no-write-allocate data cache for MEM
// Revision : 1.0
// ============================================================================
module dcache #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MCACHE_ADR_SM,
  input  logic [31:0] MCACHE_DATA_SM,
  input  logic        MCACHE_ADR_VALID_SM,
  input  logic        MCACHE_LOAD_SM,
  input  logic        MCACHE_STORE_SM,
  input  logic [3:0]  byt_sel,
  output logic [31:0] MCACHE_RESULT_SM,
  output logic        MCACHE_STALL_SM,
  output logic        BUS_ERROR_SX,
  output logic        DBUS_REQ,
  output logic        DBUS_WE,
  output logic [31:0] DBUS_ADR,
  output logic [31:0] DBUS_WDATA,
  output logic [3:0]  DBUS_BE,
  input  logic        DBUS_ACK,
  input  logic [31:0] DBUS_RDATA,
  input  logic        DBUS_ERR
);
  localparam int WOFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(SETS);
  localparam int TAG_LSB = 2 + WOFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;
  localparam int MEM_AW  = IDX_W + WOFF_W;
  localparam int CNT_W   = (WOFF_W > 0) ? WOFF_W : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LINE_WORDS - 1);
  localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_WRITE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic              req_q, req_d, we_q, we_d;
  logic [31:0]       adr_q, adr_d, wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [31:0]       data_mem [SETS*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [SETS];

  logic              is_load, is_store;
  logic [IDX_W-1:0]  req_idx, bus_idx;
  logic [TAG_W-1:0]  req_tag, bus_tag;
  logic [MEM_AW-1:0] req_maddr, bus_maddr;
  logic              req_hit, bus_hit;
  logic [31:0]       req_word, bus_word, lane_data, merged;
  logic              stall, bus_err, xfer_end, mem_we, tag_we;
  logic [31:0]       result, mem_wdata;

  // Load and store together is a store.
  assign is_store  = MCACHE_ADR_VALID_SM & MCACHE_STORE_SM;
  assign is_load   = MCACHE_ADR_VALID_SM & MCACHE_LOAD_SM & ~MCACHE_STORE_SM;

  assign req_idx   = MCACHE_ADR_SM[TAG_LSB-1 -: IDX_W];
  assign req_tag   = MCACHE_ADR_SM[31:TAG_LSB];
  assign req_maddr = MCACHE_ADR_SM[TAG_LSB-1:2];
  assign req_hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign req_word  = data_mem[req_maddr];

  // The bus address register always points at the word being transferred.
  assign bus_idx   = adr_q[TAG_LSB-1 -: IDX_W];
  assign bus_tag   = adr_q[31:TAG_LSB];
  assign bus_maddr = adr_q[TAG_LSB-1:2];
  assign bus_hit   = valid_q[bus_idx] && (tag_mem[bus_idx] == bus_tag);
  assign bus_word  = data_mem[bus_maddr];

  always_comb begin
    lane_data = MCACHE_DATA_SM;
    case ($countones(byt_sel))
      1:       lane_data = {24'd0, MCACHE_DATA_SM[7:0]} << {MCACHE_ADR_SM[1:0], 3'b000};
      2:       lane_data = {16'd0, MCACHE_DATA_SM[15:0]} << {MCACHE_ADR_SM[1], 4'b0000};
      default: lane_data = MCACHE_DATA_SM;
    endcase
  end

  always_comb begin
    merged = bus_word;
    for (int b = 0; b < 4; b++) begin
      if (be_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    req_d     = req_q;
    we_d      = we_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    stall     = 1'b0;
    result    = 32'd0;
    bus_err   = 1'b0;
    xfer_end  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = DBUS_RDATA;
    tag_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_load) begin
          if (req_hit) begin
            result = req_word;
          end else begin
            stall            = 1'b1;
            cnt_d            = '0;
            valid_d[req_idx] = 1'b0;
            req_d            = 1'b1;
            we_d             = 1'b0;
            adr_d            = MCACHE_ADR_SM & ~LINE_MASK;
            be_d             = 4'hF;
            wdata_d          = 32'd0;
            state_d          = S_FILL;
          end
        end else if (is_store && byt_sel != 4'd0) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = {MCACHE_ADR_SM[31:2], 2'b00};
          be_d    = byt_sel;
          wdata_d = lane_data;
          state_d = S_WRITE;
        end
      end
      S_FILL: begin
        stall = 1'b1;
        if (DBUS_ERR) begin
          stall    = 1'b0;
          bus_err  = 1'b1;
          xfer_end = 1'b1;
        end else if (DBUS_ACK) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          adr_d  = adr_q + 32'd4;
          if (cnt_q == CNT_LAST) begin
            tag_we           = 1'b1;
            valid_d[bus_idx] = 1'b1;
            cnt_d            = '0;
            xfer_end         = 1'b1;
          end
        end
      end
      S_WRITE: begin
        stall = 1'b1;
        if (DBUS_ERR) begin
          stall    = 1'b0;
          bus_err  = 1'b1;
          xfer_end = 1'b1;
        end else if (DBUS_ACK) begin
          stall     = 1'b0;
          mem_we    = bus_hit;
          mem_wdata = merged;
          xfer_end  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (xfer_end) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      adr_d   = 32'd0;
      wdata_d = 32'd0;
      be_d    = 4'd0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) data_mem[bus_maddr] <= mem_wdata;
    if (tag_we) tag_mem[bus_idx]    <= bus_tag;
  end

  assign MCACHE_STALL_SM  = stall & ~reset;
  assign MCACHE_RESULT_SM = reset ? 32'd0 : result;
  assign BUS_ERROR_SX     = bus_err & ~reset;
  assign DBUS_REQ         = req_q;
  assign DBUS_WE          = we_q;
  assign DBUS_ADR         = adr_q;
  assign DBUS_WDATA       = wdata_q;
  assign DBUS_BE          = be_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache
// Purpose  : scoreboard bench for dcache against a line-level reference model
// Revision : 1.0
// ============================================================================
module tb_dcache;
  localparam int SETS = 64;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MCACHE_ADR_SM, MCACHE_DATA_SM;
  logic        MCACHE_ADR_VALID_SM, MCACHE_LOAD_SM, MCACHE_STORE_SM;
  logic [3:0]  byt_sel;
  logic [31:0] MCACHE_RESULT_SM;
  logic        MCACHE_STALL_SM, BUS_ERROR_SX;
  logic        DBUS_REQ, DBUS_WE;
  logic [31:0] DBUS_ADR, DBUS_WDATA;
  logic [3:0]  DBUS_BE;
  logic        DBUS_ACK, DBUS_ERR;
  logic [31:0] DBUS_RDATA;

  dcache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset),
    .MCACHE_ADR_SM(MCACHE_ADR_SM), .MCACHE_DATA_SM(MCACHE_DATA_SM),
    .MCACHE_ADR_VALID_SM(MCACHE_ADR_VALID_SM), .MCACHE_LOAD_SM(MCACHE_LOAD_SM),
    .MCACHE_STORE_SM(MCACHE_STORE_SM), .byt_sel(byt_sel),
    .MCACHE_RESULT_SM(MCACHE_RESULT_SM), .MCACHE_STALL_SM(MCACHE_STALL_SM),
    .BUS_ERROR_SX(BUS_ERROR_SX), .DBUS_REQ(DBUS_REQ), .DBUS_WE(DBUS_WE),
    .DBUS_ADR(DBUS_ADR), .DBUS_WDATA(DBUS_WDATA), .DBUS_BE(DBUS_BE),
    .DBUS_ACK(DBUS_ACK), .DBUS_RDATA(DBUS_RDATA), .DBUS_ERR(DBUS_ERR)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] adr; logic [3:0] be; logic [31:0] wdata; } op_t;
  typedef struct packed { logic [31:0] result; logic err; } resp_t;

  op_t   exp_ops[$];
  resp_t exp_resp[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference model: memory image plus per-set valid/tag, no data copy needed
  // because a write-through cache always mirrors memory for resident lines.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];
  bit          mvalid  [SETS];
  int unsigned mtag    [SETS];

  int wait_max  = 0;
  int err_beat  = -1;
  int hold_beat = -1;
  int beat      = 0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic void chk(string name, bit ok, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Bus slave: random wait states, scripted error/hold beats.
  initial begin
    int wcnt, cur_wait;
    wcnt = 0; cur_wait = 0;
    DBUS_ACK = 1'b0; DBUS_ERR = 1'b0; DBUS_RDATA = 32'd0;
    forever begin
      @(posedge clk); #1;
      DBUS_ACK = 1'b0; DBUS_ERR = 1'b0; DBUS_RDATA = 32'd0;
      if (!reset && DBUS_REQ && beat != hold_beat) begin
        if (wcnt < cur_wait) wcnt++;
        else begin
          wcnt = 0;
          cur_wait = $urandom_range(0, wait_max);
          if (beat == err_beat) DBUS_ERR = 1'b1;
          else begin
            DBUS_ACK = 1'b1;
            if (DBUS_WE) begin
              logic [31:0] w;
              w = bus_rd(DBUS_ADR);
              for (int b = 0; b < 4; b++) if (DBUS_BE[b]) w[8*b +: 8] = DBUS_WDATA[8*b +: 8];
              bus_mem[DBUS_ADR] = w;
            end else DBUS_RDATA = bus_rd(DBUS_ADR);
          end
          beat++;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes a bus beat or a request.
  initial begin
    op_t op; resp_t rs;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (DBUS_REQ && (DBUS_ACK || DBUS_ERR)) begin
        if (exp_ops.size() == 0) chk("bus_unexpected", 1'b0, DBUS_ADR, 32'hFFFFFFFF);
        else begin
          op = exp_ops.pop_front();
          chk("bus_we",  DBUS_WE == op.we,  {31'd0, DBUS_WE}, {31'd0, op.we});
          chk("bus_adr", DBUS_ADR == op.adr, DBUS_ADR, op.adr);
          chk("bus_be",  DBUS_BE == op.be,  {28'd0, DBUS_BE}, {28'd0, op.be});
          if (op.we) chk("bus_wdata", DBUS_WDATA == op.wdata, DBUS_WDATA, op.wdata);
        end
      end
      if (MCACHE_ADR_VALID_SM && (MCACHE_LOAD_SM || MCACHE_STORE_SM)) begin
        if (!MCACHE_STALL_SM) begin
          if (exp_resp.size() == 0) chk("resp_unexpected", 1'b0, MCACHE_RESULT_SM, 32'hFFFFFFFF);
          else begin
            rs = exp_resp.pop_front();
            chk("result", MCACHE_RESULT_SM == rs.result, MCACHE_RESULT_SM, rs.result);
            chk("bus_error", BUS_ERROR_SX == rs.err, {31'd0, BUS_ERROR_SX}, {31'd0, rs.err});
          end
        end else chk("err_during_stall", BUS_ERROR_SX == 1'b0, {31'd0, BUS_ERROR_SX}, 32'd0);
      end else begin
        chk("idle_quiet", MCACHE_RESULT_SM == 32'd0 && !MCACHE_STALL_SM && !BUS_ERROR_SX,
            MCACHE_RESULT_SM | {31'd0, MCACHE_STALL_SM | BUS_ERROR_SX}, 32'd0);
      end
    end
  end

  task automatic issue(input bit st, input bit ld_too, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] bs, input int eb);
    int unsigned idx, tag;
    logic [31:0] wa, base, lanes, w;
    idx  = (a / (LW * 4)) % SETS;
    tag  = a / (LW * 4 * SETS);
    wa   = a & ~32'd3;
    base = a & ~32'(LW * 4 - 1);
    err_beat = eb;
    beat     = 0;
    if (!st) begin
      if (mvalid[idx] && mtag[idx] == tag) exp_resp.push_back('{ref_rd(wa), 1'b0});
      else begin
        mvalid[idx] = 1'b0;
        for (int b = 0; b < LW; b++) begin
          exp_ops.push_back('{1'b0, base + 32'(4 * b), 4'hF, 32'd0});
          if (b == eb) break;
        end
        if (eb >= 0 && eb < LW) exp_resp.push_back('{32'd0, 1'b1});
        else begin
          exp_resp.push_back('{ref_rd(wa), 1'b0});
          mvalid[idx] = 1'b1;
          mtag[idx]   = tag;
        end
      end
    end else if (bs == 4'd0) begin
      exp_resp.push_back('{32'd0, 1'b0});
    end else begin
      case (bs)
        4'h1, 4'h2, 4'h4, 4'h8: lanes = {24'd0, d[7:0]} << (8 * a[1:0]);
        4'h3, 4'hC:             lanes = {16'd0, d[15:0]} << (16 * a[1]);
        default:                lanes = d;
      endcase
      exp_ops.push_back('{1'b1, wa, bs, lanes});
      if (eb == 0) exp_resp.push_back('{32'd0, 1'b1});
      else begin
        exp_resp.push_back('{32'd0, 1'b0});
        w = ref_rd(wa);
        for (int b = 0; b < 4; b++) if (bs[b]) w[8*b +: 8] = lanes[8*b +: 8];
        ref_mem[wa] = w;
      end
    end
    MCACHE_ADR_SM       = a;
    MCACHE_DATA_SM      = d;
    byt_sel             = bs;
    MCACHE_LOAD_SM      = st ? ld_too : 1'b1;
    MCACHE_STORE_SM     = st;
    MCACHE_ADR_VALID_SM = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!MCACHE_STALL_SM) break;
      cyc++;
      if (cyc > 300) begin
        chk("stall_timeout", 1'b0, 32'(cyc), 32'd300);
        finish_sim();
      end
    end
    @(posedge clk); #1;
    MCACHE_ADR_VALID_SM = 1'b0;
    MCACHE_LOAD_SM      = 1'b0;
    MCACHE_STORE_SM     = 1'b0;
  endtask

  task automatic do_req(input bit st, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] bs, input int eb, output int cyc);
    issue(st, 1'b0, a, d, bs, eb);
    wait_done(cyc);
  endtask

  initial begin
    int cyc;
    logic [31:0] a;
    reset = 1'b1;
    MCACHE_ADR_SM = 0; MCACHE_DATA_SM = 0; byt_sel = 0;
    MCACHE_ADR_VALID_SM = 0; MCACHE_LOAD_SM = 0; MCACHE_STORE_SM = 0;
    for (int i = 0; i < SETS; i++) begin mvalid[i] = 1'b0; mtag[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {MCACHE_STALL_SM, BUS_ERROR_SX, DBUS_REQ, DBUS_WE} == 4'd0 &&
        MCACHE_RESULT_SM == 0 && DBUS_ADR == 0 && DBUS_WDATA == 0 && DBUS_BE == 0,
        MCACHE_RESULT_SM | DBUS_ADR | DBUS_WDATA, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Cold load miss fills the whole line with zero-wait bus.
    do_req(1'b0, 32'h100, 32'h0, 4'hF, -1, cyc);
    chk("lat_load_miss", cyc == LW + 1, 32'(cyc), 32'(LW + 1));
    do_req(1'b0, 32'h108, 32'h0, 4'hF, -1, cyc);
    chk("lat_load_hit", cyc == 0, 32'(cyc), 32'd0);
    do_req(1'b1, 32'h101, 32'hFFFF_FFAB, 4'b0010, -1, cyc);
    chk("lat_store", cyc == 1, 32'(cyc), 32'd1);
    do_req(1'b0, 32'h100, 32'h0, 4'hF, -1, cyc);
    chk("lat_reload_hit", cyc == 0, 32'(cyc), 32'd0);
    // No-write-allocate: store miss writes the bus only.
    do_req(1'b1, 32'h2000, 32'h1234_5678, 4'hF, -1, cyc);
    do_req(1'b0, 32'h2000, 32'h0, 4'hF, -1, cyc);
    chk("lat_after_store_miss", cyc == LW + 1, 32'(cyc), 32'(LW + 1));
    // Misaligned store completes without bus traffic.
    do_req(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0000, -1, cyc);
    chk("lat_misaligned", cyc == 0, 32'(cyc), 32'd0);
    // Error on the second fill word, then a clean refill.
    do_req(1'b0, 32'h300, 32'h0, 4'hF, 1, cyc);
    chk("lat_fill_err", cyc == 2, 32'(cyc), 32'd2);
    do_req(1'b0, 32'h304, 32'h0, 4'hF, -1, cyc);
    chk("lat_refill", cyc == LW + 1, 32'(cyc), 32'(LW + 1));
    // Store error leaves memory and cache untouched.
    do_req(1'b1, 32'h108, 32'h5555_5555, 4'hF, 0, cyc);
    do_req(1'b0, 32'h108, 32'h0, 4'hF, -1, cyc);

    // Reset while the fill is parked on word 2.
    hold_beat = 2;
    issue(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, -1);
    for (int i = 0; i < 50 && !(beat == 2 && DBUS_REQ); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("fill_parked_req", DBUS_REQ == 1'b1, {31'd0, DBUS_REQ}, 32'd1);
    @(posedge clk); #3;
    reset = 1'b1;
    MCACHE_ADR_VALID_SM = 1'b0; MCACHE_LOAD_SM = 1'b0;
    #1;
    chk("reset_mid_fill_req", DBUS_REQ == 1'b0, {31'd0, DBUS_REQ}, 32'd0);
    chk("reset_mid_fill_outs", {MCACHE_STALL_SM, BUS_ERROR_SX, DBUS_WE} == 3'd0 &&
        MCACHE_RESULT_SM == 0 && DBUS_ADR == 0 && DBUS_BE == 0,
        MCACHE_RESULT_SM | DBUS_ADR | {28'd0, DBUS_BE}, 32'd0);
    exp_ops.delete();
    exp_resp.delete();
    for (int i = 0; i < SETS; i++) mvalid[i] = 1'b0;
    hold_beat = -1;
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(1'b0, 32'h400, 32'h0, 4'hF, -1, cyc);
    chk("lat_post_reset_miss", cyc == LW + 1, 32'(cyc), 32'(LW + 1));
    do_req(1'b0, 32'h100, 32'h0, 4'hF, -1, cyc);
    chk("lat_post_reset_other", cyc == LW + 1, 32'(cyc), 32'(LW + 1));

    // Randomized traffic over a small address pool to force hits and conflicts.
    wait_max = 3;
    for (int n = 0; n < 400; n++) begin
      int k, eb;
      bit st, both;
      logic [3:0] bs;
      a = 32'(($urandom_range(0, 2) << 10) | ($urandom_range(0, 3) << 4) |
              ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | 32'h0001_0000;
      st   = ($urandom_range(0, 9) >= 6);
      both = ($urandom_range(0, 3) == 0);
      bs   = 4'hF;
      if (st) begin
        k = $urandom_range(0, 9);
        if (k <= 3)      bs = 4'd1 << a[1:0];
        else if (k <= 6) begin a[0] = 1'b0; bs = a[1] ? 4'b1100 : 4'b0011; end
        else if (k <= 8) begin a[1:0] = 2'b00; bs = 4'hF; end
        else             bs = 4'd0;
        eb = ($urandom_range(0, 11) == 0) ? 0 : -1;
      end else begin
        eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      end
      issue(st, both, a, $urandom, bs, eb);
      wait_done(cyc);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    chk("ops_drained", exp_ops.size() == 0, 32'(exp_ops.size()), 32'd0);
    chk("resp_drained", exp_resp.size() == 0, 32'(exp_resp.size()), 32'd0);
    finish_sim();
  end

endmodule
`default_nettype wire
